// File: rtl/interval_timer_arb.sv
// interval_timer_arb: round-robin shared down-counting interval timer
// Optional abort-on-request-drop support is enabled by defining TSA_ABORT_EN.
module interval_timer_arb #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*CNT_W-1:0] len,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic [CNT_W-1:0]   q,
   output logic               done,
   output logic [ID_W-1:0]    done_id,
   output logic               aborted
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   logic [0:0]      state;
   logic [ID_W-1:0] w;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] pick;
   // Scan downward in offset so the nearest requester at or above rr_ptr wins last.
   always_comb begin
      pick = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (req[(int'(rr_ptr) + i) % N_REQ]) pick = ID_W'((int'(rr_ptr) + i) % N_REQ);
   end
   assign busy    = state == RUN;
   assign grant   = busy ? N_REQ'(1) << w : '0;
   assign done    = busy && q == '0;
   assign done_id = done ? w : '0;
`ifdef TSA_ABORT_EN
   assign aborted = busy && q != '0 && !req[w];
`else
   assign aborted = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         q      <= '0;
         w      <= '0;
         rr_ptr <= '0;
      end else if (state == IDLE) begin
         if (|req) begin
            state <= RUN;
            w     <= pick;
            q     <= len[int'(pick)*CNT_W +: CNT_W];
         end
      end else if (done || aborted) begin
         state  <= IDLE;
         rr_ptr <= (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
      end else begin
         q <= q - 1'b1;
      end
   end
endmodule

// File: tb/tb_interval_timer_arb.sv
// tb_interval_timer_arb: scoreboard bench; expected grants are queued as stimulus is applied
// and retired against each done pulse seen by the monitor.
module tb_interval_timer_arb;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] len = '0;
   logic [3:0]  grant;
   logic        busy;
   logic [3:0]  q;
   logic        done;
   logic [1:0]  done_id;
   logic        aborted;

   interval_timer_arb dut (
      .clk(clk), .reset(reset), .req(req), .len(len), .grant(grant), .busy(busy),
      .q(q), .done(done), .done_id(done_id), .aborted(aborted)
   );

   always #5 clk = ~clk;

   typedef struct { int id; int cyc; } exp_t;
   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;
   int nd = 0;
   int na = 0;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_run(input int id, input int cyc);
      sb.push_back('{id, cyc});
   endtask

   task automatic wait_done(input int target);
      for (int c = 0; c < 300 && nd < target; c++) tick();
      check("timeout", nd, target);
   endtask

   task automatic do_reset();
      req = '0;
      reset = 1'b1;
      tick();
      tick();
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_q", q, 0);
      check("rst_done", done, 0);
      check("rst_done_id", done_id, 0);
      check("rst_aborted", aborted, 0);
      reset = 1'b0;
   endtask

   // Monitor: tracks each grant, checks q countdown, grant shape and idle gap, retires on done.
   initial begin
      bit in_run = 0;
      bit pdone = 0;
      int cnt = 0;
      int start_q = 0;
      int cur_id = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_run = 0;
            pdone = 0;
         end else begin
            if (pdone) check("idle_gap", busy, 0);
            if (busy && !in_run) begin
               in_run = 1;
               cnt = 0;
               start_q = q;
               cur_id = 0;
               for (int i = 0; i < 4; i++) if (grant[i]) cur_id = i;
            end
            if (in_run) begin
               cnt++;
               check("q", q, start_q - cnt + 1);
               check("grant", grant, 1 << cur_id);
            end
`ifndef TSA_ABORT_EN
            check("aborted_tied", aborted, 0);
`else
            if (aborted) begin
               in_run = 0;
               na++;
            end
`endif
            if (done) begin
               check("done_busy", busy, 1);
               if (sb.size() == 0) check("unexpected_done", 1, 0);
               else begin
                  e = sb.pop_front();
                  check("done_id", done_id, e.id);
                  check("winner", cur_id, e.id);
                  check("cycles", cnt, e.cyc);
               end
               in_run = 0;
               nd++;
            end
            pdone = done;
         end
      end
   end

   initial begin
      int t;
      do_reset();
      // single requester, len 3
      len = 16'h0003;
      req = 4'b0001;
      expect_run(0, 4);
      t = nd + 1;
      wait_done(t);
      req = '0;
      tick();
      do_reset();
      // all request, len 1: strict rotation
      len = 16'h1111;
      req = 4'b1111;
      expect_run(0, 2); expect_run(1, 2); expect_run(2, 2); expect_run(3, 2); expect_run(0, 2);
      t = nd + 5;
      wait_done(t);
      req = '0;
      tick();
      do_reset();
      // alternating requesters with len 0
      len = 16'h0000;
      req = 4'b0101;
      expect_run(0, 1); expect_run(2, 1); expect_run(0, 1); expect_run(2, 1);
      t = nd + 4;
      wait_done(t);
      req = '0;
      tick();
      do_reset();
      // maximum length, no wrap; leaves rr_ptr at 2
      len = 16'h00F0;
      req = 4'b0010;
      expect_run(1, 16);
      t = nd + 1;
      wait_done(t);
      req = '0;
      tick();
      check("busy_after_max", busy, 0);
      // reset mid-run at q=2: arbitration must restart from id 0
      len = 16'h1151;
      req = 4'b0010;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (busy && q == 4'd2) break;
      end
      check("reached_q2", q, 2);
      reset = 1'b1;
      req = 4'b1011;
      tick();
      check("midrst_grant", grant, 0);
      check("midrst_busy", busy, 0);
      check("midrst_q", q, 0);
      check("midrst_done", done, 0);
      reset = 1'b0;
      expect_run(0, 2);
      t = nd + 1;
      wait_done(t);
      req = '0;
      tick();
      do_reset();
      // drop request mid-run at q=3
      len = 16'h0050;
      req = 4'b0010;
`ifndef TSA_ABORT_EN
      expect_run(1, 6);
`endif
      for (int c = 0; c < 50; c++) begin
         tick();
         if (busy && q == 4'd3) break;
      end
      check("reached_q3", q, 3);
      req = '0;
`ifdef TSA_ABORT_EN
      #3;
      check("abort_pulse", aborted, 1);
      check("abort_no_done", done, 0);
      tick();
      check("abort_grant", grant, 0);
      check("abort_count", na, 1);
`else
      t = nd + 1;
      wait_done(t);
      tick();
`endif
      tick();
      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
